// File: rtl/keypad_input.sv
// Scans a 4x4 active-low hex keypad and two push-buttons, debounces them and
// assembles up to eight hex digits into a word offered through valid/ack.
module keypad_input #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEBOUNCE = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  key_row,
  input  logic [3:0]  key_col,
  input  logic        btn_confirm,
  input  logic        btn_clear,
  input  logic        data_ack,
  output logic [31:0] entry_data,
  output logic [3:0]  digit_count,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        key_pulse
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} key_state_t;

  logic [3:0]    col_s1, col_s2;
  logic [1:0]    btn_s1, btn_s2;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    row_idx;
  logic [11:0]   snap;
  logic          scan_tc_c, frame_end_c;
  logic [15:0]   frame_snap_c;
  logic          none_c, single_c;
  logic [3:0]    code_c;
  key_state_t    state, state_n;
  logic [DW-1:0] cnt, cnt_n;
  logic [3:0]    key, key_n;
  logic          digit_ev_c;
  logic [1:0]    btn_db;
  logic [DW-1:0] btn_cnt [2];
  logic [1:0]    btn_rise_c;
  logic          conf_ev_c, clr_ev_c, conf_ok_c;

  // Two-stage synchronizers; bit 0 = confirm, bit 1 = clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
      btn_s1 <= 2'b00;
      btn_s2 <= 2'b00;
    end else begin
      col_s1 <= key_col;
      col_s2 <= col_s1;
      btn_s1 <= {btn_clear, btn_confirm};
      btn_s2 <= btn_s1;
    end
  end

  assign scan_tc_c    = (scan_cnt == CW'(SCAN_DIV - 1));
  assign frame_end_c  = scan_tc_c && (row_idx == 2'd3);
  assign frame_snap_c = {~col_s2, snap};

  // Row scan: pressed keys are stored active-high, row r in snap[4r+3:4r]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      row_idx  <= 2'd0;
      key_row  <= 4'b1110;
      snap     <= '0;
    end else if (scan_tc_c) begin
      scan_cnt <= '0;
      row_idx  <= row_idx + 2'd1;
      key_row  <= {key_row[2:0], key_row[3]};
      unique case (row_idx)
        2'd0:    snap[3:0]  <= ~col_s2;
        2'd1:    snap[7:4]  <= ~col_s2;
        2'd2:    snap[11:8] <= ~col_s2;
        default: ;
      endcase
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  // Frame classification; bit position r*4+c is exactly the key code
  always_comb begin
    none_c   = (frame_snap_c == 16'd0);
    single_c = !none_c && ((frame_snap_c & (frame_snap_c - 16'd1)) == 16'd0);
    code_c   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_snap_c[i]) code_c = 4'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      key   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      key   <= key_n;
    end
  end

  // Key FSM; MULTI is treated like NONE for release
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    key_n      = key;
    digit_ev_c = 1'b0;
    if (frame_end_c) begin
      unique case (state)
        IDLE: begin
          if (single_c) begin
            key_n   = code_c;
            cnt_n   = DW'(1);
            state_n = PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (single_c && (code_c == key)) begin
            if (cnt == DW'(DEBOUNCE - 1)) begin
              digit_ev_c = 1'b1;
              state_n    = HELD;
            end else begin
              cnt_n = cnt + DW'(1);
            end
          end else begin
            state_n = IDLE;
          end
        end
        HELD: begin
          if (!single_c) begin
            cnt_n   = DW'(1);
            state_n = RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          if (!single_c) begin
            if (cnt == DW'(DEBOUNCE - 1)) state_n = IDLE;
            else                          cnt_n   = cnt + DW'(1);
          end else begin
            state_n = HELD;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Button debouncers, sampled once per row dwell
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db <= 2'b00;
      for (int i = 0; i < 2; i++) btn_cnt[i] <= '0;
    end else if (scan_tc_c) begin
      for (int i = 0; i < 2; i++) begin
        if (btn_s2[i] != btn_db[i]) begin
          if (btn_cnt[i] == DW'(DEBOUNCE - 1)) begin
            btn_db[i]  <= btn_s2[i];
            btn_cnt[i] <= '0;
          end else begin
            btn_cnt[i] <= btn_cnt[i] + DW'(1);
          end
        end else begin
          btn_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    btn_rise_c = 2'b00;
    for (int i = 0; i < 2; i++) begin
      btn_rise_c[i] = scan_tc_c && btn_s2[i] && !btn_db[i] &&
                      (btn_cnt[i] == DW'(DEBOUNCE - 1));
    end
  end

  assign conf_ev_c = btn_rise_c[0];
  assign clr_ev_c  = btn_rise_c[1];
  assign conf_ok_c = conf_ev_c && !clr_ev_c && (!data_valid || data_ack);

  // Entry word and output handshake; clear beats confirm beats digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_data  <= '0;
      digit_count <= 4'd0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      key_pulse   <= 1'b0;
    end else begin
      key_pulse <= digit_ev_c && !clr_ev_c && !conf_ev_c;
      if (clr_ev_c) begin
        entry_data  <= '0;
        digit_count <= 4'd0;
      end else if (conf_ev_c) begin
        if (conf_ok_c) begin
          entry_data  <= '0;
          digit_count <= 4'd0;
        end
      end else if (digit_ev_c && (digit_count < 4'd8)) begin
        entry_data  <= {entry_data[27:0], key};
        digit_count <= digit_count + 4'd1;
      end
      if (conf_ok_c) begin
        data_out   <= entry_data;
        data_valid <= 1'b1;
      end else if (data_ack) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_input.sv
// Scoreboard bench for keypad_input: keypad model drives columns, a monitor
// checks every key_pulse and every data_valid rise against queued expectations.
module tb_keypad_input;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic        btn_confirm = 1'b0;
  logic        btn_clear = 1'b0;
  logic        data_ack = 1'b0;
  logic [31:0] entry_data;
  logic [3:0]  digit_count;
  logic [31:0] data_out;
  logic        data_valid;
  logic        key_pulse;

  logic [15:0] pressed = 16'd0;

  typedef struct packed {
    logic [31:0] entry;
    logic [3:0]  cnt;
  } key_exp_t;

  key_exp_t    key_q[$];
  logic [31:0] conf_q[$];
  key_exp_t    mon_e;
  logic [31:0] mon_d;
  logic        dv_prev = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          pulse_seen = 0;

  keypad_input #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk(clk), .rst_n(rst_n), .key_row(key_row), .key_col(key_col),
    .btn_confirm(btn_confirm), .btn_clear(btn_clear), .data_ack(data_ack),
    .entry_data(entry_data), .digit_count(digit_count), .data_out(data_out),
    .data_valid(data_valid), .key_pulse(key_pulse)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    key_col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!key_row[r] && pressed[r*4+c]) key_col[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_key(input logic [31:0] e, input logic [3:0] n);
    key_exp_t k;
    k.entry = e;
    k.cnt   = n;
    key_q.push_back(k);
  endtask

  task automatic press_key(input int code, input int hold, input int rel);
    pressed[code] = 1'b1;
    repeat (hold * 16) @(negedge clk);
    pressed = 16'd0;
    repeat (rel * 16) @(negedge clk);
  endtask

  task automatic press_btn(input logic conf, input logic clr);
    btn_confirm = conf;
    btn_clear   = clr;
    repeat (40) @(negedge clk);
    btn_confirm = 1'b0;
    btn_clear   = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  // Monitor: compares whenever the DUT presents a key event or a new word
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_pulse) begin
        pulse_seen++;
        if (key_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_key_pulse: got entry %h count %0d, required no pulse",
                   entry_data, digit_count);
        end else begin
          mon_e = key_q.pop_front();
          check("pulse_entry", entry_data, mon_e.entry);
          check("pulse_count", 32'(digit_count), 32'(mon_e.cnt));
        end
      end
      if (data_valid && !dv_prev) begin
        if (conf_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got data_out %h, required no valid rise", data_out);
        end else begin
          mon_d = conf_q.pop_front();
          check("confirm_data", data_out, mon_d);
          check("confirm_entry_cleared", entry_data, 32'h0);
          check("confirm_count_cleared", 32'(digit_count), 32'h0);
        end
      end
    end
    dv_prev = data_valid;
  end

  initial begin
    logic [3:0]  rows [5];
    logic [31:0] exp_e;
    int          p0;
    rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_key_row", 32'(key_row), 32'hE);
    check("rst_entry", entry_data, 32'h0);
    check("rst_count", 32'(digit_count), 32'h0);
    check("rst_data_out", data_out, 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_pulse", 32'(key_pulse), 32'h0);
    rst_n = 1'b1;

    // Row rotation, one step per 4 cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("row_0", 32'(key_row), 32'(rows[0]));
    for (int i = 1; i < 5; i++) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("row_rot", 32'(key_row), 32'(rows[i]));
    end

    // Single press of row 1 / column 2, held 6 frames
    p0 = pulse_seen;
    push_key(32'h6, 4'd1);
    press_key(6, 6, 4);
    check("single_pulses", 32'(pulse_seen - p0), 32'd1);
    check("single_entry", entry_data, 32'h6);
    check("single_count", 32'(digit_count), 32'd1);

    press_btn(1'b0, 1'b1);
    check("clear_entry", entry_data, 32'h0);
    check("clear_count", 32'(digit_count), 32'h0);

    // Digits 1..9; ninth pulses but is discarded
    exp_e = 32'h0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_e = {exp_e[27:0], 4'(i)};
      push_key(exp_e, (i <= 8) ? 4'(i) : 4'd8);
      press_key(i, 4, 4);
    end
    check("full_entry", entry_data, 32'h12345678);
    check("full_count", 32'(digit_count), 32'd8);

    // Bouncing key and two-key chord give no events
    p0 = pulse_seen;
    for (int i = 0; i < 5; i++) press_key(6, 1, 1);
    repeat (32) @(negedge clk);
    pressed[4] = 1'b1;
    pressed[7] = 1'b1;
    repeat (96) @(negedge clk);
    pressed = 16'd0;
    repeat (64) @(negedge clk);
    check("no_pulse_bounce_multi", 32'(pulse_seen - p0), 32'd0);
    check("entry_kept", entry_data, 32'h12345678);

    // Confirm, then a second confirm while still valid is ignored
    conf_q.push_back(32'h12345678);
    press_btn(1'b1, 1'b0);
    check("valid_after_confirm", 32'(data_valid), 32'd1);
    push_key(32'hA, 4'd1);
    press_key(10, 4, 4);
    push_key(32'hAB, 4'd2);
    press_key(11, 4, 4);
    press_btn(1'b1, 1'b0);
    check("ignored_confirm_entry", entry_data, 32'hAB);
    check("ignored_confirm_count", 32'(digit_count), 32'd2);
    check("ignored_confirm_data", data_out, 32'h12345678);
    check("ignored_confirm_valid", 32'(data_valid), 32'd1);

    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    check("ack_drops_valid", 32'(data_valid), 32'd0);

    // Clear and confirm together: clear wins, nothing delivered
    press_btn(1'b1, 1'b1);
    check("clr_conf_entry", entry_data, 32'h0);
    check("clr_conf_count", 32'(digit_count), 32'h0);
    check("clr_conf_valid", 32'(data_valid), 32'd0);

    // Reset while a key is held; it registers again after reset
    push_key(32'h5, 4'd1);
    pressed[5] = 1'b1;
    repeat (96) @(negedge clk);
    check("held_entry", entry_data, 32'h5);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_key_row", 32'(key_row), 32'hE);
    check("midrst_entry", entry_data, 32'h0);
    check("midrst_count", 32'(digit_count), 32'h0);
    push_key(32'h5, 4'd1);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rereg_not_early", 32'(key_q.size()), 32'd1);
    repeat (16) @(negedge clk);
    check("rereg_in_time", 32'(key_q.size()), 32'd0);
    pressed = 16'd0;
    repeat (64) @(negedge clk);

    check("key_q_drained", 32'(key_q.size()), 32'd0);
    check("conf_q_drained", 32'(conf_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
